pulse_tx: RTL

- Transmit-side companion to the input debouncer. Generates clean, glitch-free pulses on an output pin from CPU-side requests.
- Each pulse has an exact high time and a guaranteed minimum low gap, so a downstream debouncing receiver always sees one event per pulse.
- Requests are counted in a saturating pending counter, so bursts can be queued while a pulse is in progress.
- Sits between the CPLD register interface and an external pin: LED, buzzer, or a loopback into the debouncer.

---
 rtl/pulse_tx_if.sv | 24 ++
 rtl/pulse_tx.sv | 114 +++++++++++
 2 files changed

// File: rtl/pulse_tx_if.sv
// Request/status bundle between the register block and the pulse transmitter.
interface pulse_tx_if #(
    parameter int PEND_W = 4
);
    logic              req_i;
    logic [PEND_W-1:0] req_cnt_i;
    logic              abort_i;
    logic              clr_i;
    logic              sig_o;
    logic              busy_o;
    logic [PEND_W-1:0] pending_o;
    logic              done_o;
    logic              ovf_o;

    modport master (
        output req_i, req_cnt_i, abort_i, clr_i,
        input  sig_o, busy_o, pending_o, done_o, ovf_o
    );

    modport slave (
        input  req_i, req_cnt_i, abort_i, clr_i,
        output sig_o, busy_o, pending_o, done_o, ovf_o
    );
endinterface

// File: rtl/pulse_tx.sv
// Shapes queued requests into HIGH_CYC-high pulses separated by LOW_CYC-low gaps.
// Latency: a request sampled at edge N raises sig_o at edge N+1 when idle.
// No backpressure: requests saturate the pending counter and set the sticky ovf_o.
module pulse_tx #(
    parameter int CNT_W    = 8,
    parameter int HIGH_CYC = 128,
    parameter int LOW_CYC  = 128,
    parameter int PEND_W   = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    pulse_tx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_CYC - 1);
    localparam logic [PEND_W:0]   PEND_MAX  = {1'b0, {PEND_W{1'b1}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [PEND_W:0]   pend_sum;
    logic              sig_q, sig_d;
    logic              busy_q;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              launch;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        sig_d    = sig_q;
        done_d   = 1'b0;
        launch   = 1'b0;
        pend_d   = pend_q;
        ovf_d    = ovf_q & ~bus.clr_i;
        pend_sum = '0;

        case (state_q)
            IDLE: begin
                if (pend_q != '0 && !bus.abort_i) launch = 1'b1;
            end
            HIGH: begin
                // Abort cuts the high phase short but still enforces the full gap.
                if (bus.abort_i || timer_q == '0) begin
                    state_d = LOW;
                    sig_d   = 1'b0;
                    timer_d = LOW_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            LOW: begin
                if (timer_q == '0) begin
                    if (pend_q != '0 && !bus.abort_i) begin
                        launch = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d = HIGH;
            sig_d   = 1'b1;
            timer_d = HIGH_LOAD;
        end

        // launch implies pend_q != 0, so the subtraction cannot underflow.
        pend_sum = {1'b0, pend_q} - {{PEND_W{1'b0}}, launch}
                 + (bus.req_i ? {1'b0, bus.req_cnt_i} : {(PEND_W+1){1'b0}});

        if (bus.abort_i) begin
            pend_d = '0;
        end else if (pend_sum > PEND_MAX) begin
            pend_d = '1;
            ovf_d  = 1'b1;
        end else begin
            pend_d = pend_sum[PEND_W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            sig_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            sig_q   <= sig_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.sig_o     = sig_q;
    assign bus.busy_o    = busy_q;
    assign bus.pending_o = pend_q;
    assign bus.done_o    = done_q;
    assign bus.ovf_o     = ovf_q;
endmodule
